// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the SDMAC FIFO write-side controller:
// FSM state encoding, request size codes and byte-offset arithmetic.
package fifo_ctrl_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int PTR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    FLUSH_ST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2
  } size_e;

  // Offset advance in bytes; bit 2 of {0,BO}+inc flags a longword wrap.
  function automatic logic [2:0] bo_inc(input size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_WORD: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_aligned(input size_e sz, input logic [1:0] bo);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_WORD: return ~bo[0];
      default: return (bo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/fifo_occupancy.sv
// Drain-side bookkeeping: read pointer, completed-longword count and
// full/empty flags. A POP while empty is ignored.
module fifo_occupancy
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             complete,
  input  logic             pop,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      // A completion and a pop in the same cycle cancel out.
      case ({complete, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side sequencer for the SDMAC 8-longword FIFO, feeding fifo_write_strobes.
// Optional FIFO_WR_ALIGN_ERR_EN adds an ALIGN_ERR pulse on misaligned requests.
module fifo_write_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             CLK,
  input  logic             _RST,
  input  logic             BREQ,
  input  logic             WREQ,
  input  logic             LREQ,
  input  logic             FLUSH,
  input  logic             POP,
  output logic             ACK,
  output logic             FLUSHED,
  output logic             BO1,
  output logic             BO0,
  output logic             LHWORD,
  output logic             LLWORD,
  output logic             LBYTE_,
  output logic [PTR_W-1:0] WR_PTR,
  output logic [PTR_W-1:0] RD_PTR,
  output logic             FIFOFULL,
  output logic             FIFOEMPTY,
`ifdef FIFO_WR_ALIGN_ERR_EN
  output logic             ALIGN_ERR,
`endif
  output logic [PTR_W:0]   COUNT
);

  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);

  state_e           state_q, state_d;
  size_e            size_q, size_d;
  logic             aligned_q, aligned_d;
  logic [1:0]       bo_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic             ack_d, flushed_d, lh_d, ll_d, lb_d;
  logic             ack_q, flushed_q, lh_q, ll_q, lbyte_n_q;
  logic [2:0]       bo_sum;
  logic             write_done, flush_done, complete, full, empty;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q   <= IDLE;
      size_q    <= SZ_BYTE;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      aligned_q <= aligned_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    aligned_d = aligned_q;
    ack_d     = 1'b0;
    flushed_d = 1'b0;
    lh_d      = 1'b0;
    ll_d      = 1'b0;
    lb_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (FLUSH) begin
          state_d   = FLUSH_ST;
          flushed_d = 1'b1;
        end else if ((LREQ || WREQ || BREQ) && !full) begin
          state_d = WRITE;
          ack_d   = 1'b1;
          if (LREQ)      size_d = SZ_LONG;
          else if (WREQ) size_d = SZ_WORD;
          else           size_d = SZ_BYTE;
          aligned_d = is_aligned(size_d, bo_q);
          // Strobes are decided here so they are registered for the WRITE cycle.
          if (aligned_d) begin
            case (size_d)
              SZ_BYTE: lb_d = 1'b1;
              SZ_WORD: begin
                lh_d = ~bo_q[1];
                ll_d = bo_q[1];
              end
              default: begin
                lh_d = 1'b1;
                ll_d = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      ack_q     <= 1'b0;
      flushed_q <= 1'b0;
      lh_q      <= 1'b0;
      ll_q      <= 1'b0;
      lbyte_n_q <= 1'b1;
    end else begin
      ack_q     <= ack_d;
      flushed_q <= flushed_d;
      lh_q      <= lh_d;
      ll_q      <= ll_d;
      lbyte_n_q <= ~lb_d;
    end
  end

  // BO and WR_PTR move only at the end of WRITE/FLUSH_ST.
  assign bo_sum     = {1'b0, bo_q} + bo_inc(size_q);
  assign write_done = (state_q == WRITE) && aligned_q;
  assign flush_done = (state_q == FLUSH_ST) && (bo_q != 2'b00);
  assign complete   = (write_done && bo_sum[2]) || flush_done;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      bo_q     <= 2'b00;
      wr_ptr_q <= '0;
    end else begin
      if (write_done)      bo_q <= bo_sum[1:0];
      else if (flush_done) bo_q <= 2'b00;
      if (complete) wr_ptr_q <= wr_ptr_q + PTR_ONE;
    end
  end

`ifdef FIFO_WR_ALIGN_ERR_EN
  logic align_err_q;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) align_err_q <= 1'b0;
    else       align_err_q <= ack_d && !aligned_d;
  end

  assign ALIGN_ERR = align_err_q;
`endif

  fifo_occupancy #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_occupancy (
    .clk      (CLK),
    .rst_n    (_RST),
    .complete (complete),
    .pop      (POP),
    .rd_ptr   (RD_PTR),
    .count    (COUNT),
    .full     (full),
    .empty    (empty)
  );

  assign ACK       = ack_q;
  assign FLUSHED   = flushed_q;
  assign BO1       = bo_q[1];
  assign BO0       = bo_q[0];
  assign LHWORD    = lh_q;
  assign LLWORD    = ll_q;
  assign LBYTE_    = lbyte_n_q;
  assign WR_PTR    = wr_ptr_q;
  assign FIFOFULL  = full;
  assign FIFOEMPTY = empty;

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Sequencing controller for the SDMAC 8-longword FIFO write side; sits directly upstream of fifo_write_strobes.
- Accepts byte, word and longword write requests, one at a time.
- Drives BO1/BO0, LHWORD, LLWORD and LBYTE_ to the strobe decoder, and owns the write pointer, read pointer and occupancy count.
- Supports FLUSH, which pads out a partially filled longword so the drain side can consume it.

Parameters:
DEPTH, 8, number of longword entries in the FIFO.
PTR_W, 3, pointer width; DEPTH must equal 2**PTR_W.

Ports:
CLK  in  1  system clock; all state changes on rising edge.
_RST  in  1  asynchronous active-low reset.
BREQ  in  1  byte write request (SCSI side); held until ACK.
WREQ  in  1  16-bit word write request; held until ACK.
LREQ  in  1  32-bit longword write request (CPU/DMA side); held until ACK.
FLUSH  in  1  pad the current partial longword; level, sampled in IDLE.
POP  in  1  drain side consumed the entry at RD_PTR.
ACK  out  1  one-cycle pulse: request serviced.
FLUSHED  out  1  one-cycle pulse: flush complete.
BO1, BO0  out  1 each  current byte offset within the write longword.
LHWORD  out  1  load upper word, active high.
LLWORD  out  1  load lower word, active high.
LBYTE_  out  1  load byte, active low.
WR_PTR  out  PTR_W  longword entry being written.
RD_PTR  out  PTR_W  longword entry to drain.
FIFOFULL  out  1  COUNT==DEPTH.
FIFOEMPTY  out  1  COUNT==0.
COUNT  out  PTR_W+1  completed longwords held.

Behaviour:
- Reset (async, _RST low): state IDLE; BO=00, WR_PTR=0, RD_PTR=0, COUNT=0; ACK=0, FLUSHED=0, LHWORD=0, LLWORD=0, LBYTE_=1; FIFOEMPTY=1, FIFOFULL=0. Reset mid-write abandons the write: strobes drop immediately and no pointer update occurs.
- States:
  - IDLE: if FLUSH go FLUSH_ST. Otherwise, if any request is pending and !FIFOFULL, go WRITE. Priority is FLUSH > LREQ > WREQ > BREQ. FIFOFULL blocks writes only; FLUSH is still honoured.
  - WRITE (one cycle): registered strobes asserted and ACK=1. BO and WR_PTR hold their pre-write values during this cycle so the decoder sees a stable offset. Returns to IDLE.
  - FLUSH_ST (one cycle): FLUSHED=1; returns to IDLE.
- Strobes in WRITE:
  - Byte: LBYTE_=0.
  - Word: BO1=0 gives LHWORD=1; BO1=1 gives LLWORD=1.
  - Longword: LHWORD=1 and LLWORD=1.
- Alignment rules: word requires BO0=0; longword requires BO=00. A misaligned request takes the WRITE cycle with no strobes, ACK=1 and no state change.
- Update at the end of the WRITE cycle: BO += 1 (byte), 2 (word) or 4 (longword), modulo 4. On a wrap to 00 the longword is complete: WR_PTR+1 (mod DEPTH) and COUNT+1.
- Update at the end of FLUSH_ST: if BO!=00, set BO=00, WR_PTR+1 and COUNT+1; if BO==00, no change.
- POP is honoured in any state when !FIFOEMPTY: RD_PTR+1 (mod DEPTH), COUNT-1. POP while empty is ignored.
- A completion and a POP in the same cycle leave COUNT unchanged; both pointers advance.
- Throughput: one request per 2 cycles. Requests must be held until ACK; a request still high in the cycle after ACK is treated as a new request.

Optional Feature:
- Macro: FIFO_WR_ALIGN_ERR_EN.
- Defined: adds output ALIGN_ERR (1 bit, reset 0). It pulses together with ACK on a misaligned request.
- Undefined: the port is absent and misaligned requests are silently ACKed with no write. All other behaviour is identical in both builds.

Decomposition:
- Package fifo_ctrl_pkg holds: DEPTH/PTR_W defaults, state encoding (IDLE, WRITE, FLUSH_ST), size codes (SZ_BYTE, SZ_WORD, SZ_LONG) and the BO increment per size.
- One sub-module, fifo_occupancy: RD_PTR, COUNT, FULL/EMPTY and POP handling. Inputs are `complete` and POP.
- The write sequencing FSM stays in the top level.

Test Plan:
- Reset, then 4 BREQ writes → LBYTE_ low with BO=00,01,10,11 on successive ACKs; after the 4th, WR_PTR=1, COUNT=1, FIFOEMPTY=0.
- LREQ ×8 with no POP → each ACK has LHWORD=LLWORD=1; afterwards COUNT=8 and FIFOFULL=1; a 9th LREQ gets no ACK until POP, then completes with WR_PTR wrapped 0→1.
- BREQ then WREQ → WREQ at BO=01 is misaligned: ACK, no strobes, BO stays 01 (ALIGN_ERR=1 when enabled); then BREQ, WREQ → LLWORD=1 at BO=10 completes the longword, COUNT+1.
- Two BREQ then FLUSH → FLUSHED pulse, BO=00, COUNT=1, WR_PTR=1; a second FLUSH → FLUSHED pulse with no counter change.
- COUNT=3: completion and POP in the same cycle → COUNT stays 3, WR_PTR and RD_PTR both advance; POP at COUNT=0 → ignored.
- Assert _RST during a WRITE cycle → outputs reach reset values without waiting for a clock edge; no ACK; BO/WR_PTR=0.
